// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive sides.
// No logic, so no latency or backpressure.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 2604;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte queue feeding the UART transmitter.
// Head is readable with zero latency; a push while full is dropped and full/empty are registered flags.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk_25M,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int             PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + 1'b1;
    end else if (do_pop && !do_push) begin
      count_nxt = count - 1'b1;
    end
  end

  // Flags come from next occupancy so they are true flops, never a same-cycle pass-through.
  always_ff @(posedge clk_25M) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk_25M) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/uart_tx.sv
// Queued 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit, no parity.
// tx falls one cycle after a byte enters an idle empty queue; data_ready drops while the queue is full.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk_25M,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx,
  output logic       busy
);

  localparam int                CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam int                IDX_W   = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0]  IDX_MAX = IDX_W'(DATA_BITS - 1);

  uart_state_t          state;
  uart_state_t          state_nxt;
  logic [CNT_W-1:0]     baud_cnt;
  logic [CNT_W-1:0]     baud_cnt_nxt;
  logic [IDX_W-1:0]     bit_idx;
  logic [IDX_W-1:0]     bit_idx_nxt;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] shift_nxt;
  logic                 tx_nxt;
  logic                 bit_done;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic [7:0]           fifo_dat;
  logic                 fifo_full;
  logic                 fifo_empty;

  assign data_ready = !fifo_full;
  assign fifo_push  = data_valid && data_ready;
  assign bit_done   = (baud_cnt == CNT_MAX);
  assign busy       = (state != IDLE) || !fifo_empty;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_25M  (clk_25M),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat (data),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk_25M) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      shift    <= shift_nxt;
      tx       <= tx_nxt;
    end
  end

  // tx only ever changes alongside a counter clear, so it moves on bit boundaries alone.
  always_comb begin
    state_nxt    = state;
    baud_cnt_nxt = baud_cnt + 1'b1;
    bit_idx_nxt  = bit_idx;
    shift_nxt    = shift;
    tx_nxt       = tx;
    fifo_pop     = 1'b0;
    unique case (state)
      IDLE: begin
        baud_cnt_nxt = '0;
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_nxt = fifo_dat;
          tx_nxt    = 1'b0;
          state_nxt = START;
        end
      end
      START: begin
        if (bit_done) begin
          baud_cnt_nxt = '0;
          bit_idx_nxt  = '0;
          tx_nxt       = shift[0];
          state_nxt    = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          baud_cnt_nxt = '0;
          if (bit_idx == IDX_MAX) begin
            tx_nxt    = 1'b1;
            state_nxt = STOP;
          end else begin
            shift_nxt   = shift >> 1;
            tx_nxt      = shift[1];
            bit_idx_nxt = bit_idx + 1'b1;
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          baud_cnt_nxt = '0;
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            shift_nxt = fifo_dat;
            tx_nxt    = 1'b0;
            state_nxt = START;
          end else begin
            tx_nxt    = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Randomized and directed checks of uart_tx against a frame-timing reference model.
module tb_uart_tx;

  localparam int C     = 4;
  localparam int D     = 4;
  localparam int FRAME = 10 * C;

  logic       clk_25M = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic       data_valid = 1'b0;
  logic       data_ready;
  logic       tx;
  logic       busy;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of bytes, current byte, cycle position within its frame (-1 when idle).
  byte unsigned mq[$];
  logic [7:0]   m_cur   = 8'h00;
  int           m_pos   = -1;
  logic         m_ready = 1'b1;

  always #5 clk_25M = ~clk_25M;

  uart_tx #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (D)
  ) dut (
    .clk_25M    (clk_25M),
    .rst        (rst),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .tx         (tx),
    .busy       (busy)
  );

  function automatic logic exp_tx();
    int b;
    if (m_pos < 0) return 1'b1;
    b = m_pos / C;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_cur[b-1];
  endfunction

  function automatic logic exp_busy();
    return (m_pos >= 0) || (mq.size() != 0);
  endfunction

  // One clock: advance the model with the inputs present at the edge, then settle.
  task automatic tick();
    logic push;
    logic pop;
    @(posedge clk_25M);
    if (rst) begin
      mq.delete();
      m_pos   = -1;
      m_ready = 1'b1;
    end else begin
      push = data_valid && m_ready;
      pop  = ((m_pos < 0) || (m_pos == FRAME - 1)) && (mq.size() != 0);
      if (m_pos >= 0) begin
        m_pos++;
        if (m_pos == FRAME) m_pos = -1;
      end
      if (pop) begin
        m_cur = mq.pop_front();
        m_pos = 0;
      end
      if (push) mq.push_back(data);
      m_ready = (mq.size() < D);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    data_valid = 1'b1;
    data = 8'hAA;
    repeat (3) tick();
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", tx); end
    total++; if (data_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", data_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    rst = 1'b0;
    data_valid = 1'b0;
    repeat (2) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_valid_ignored busy got=%b want=0", busy); end
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_idle_tx got=%b want=1", tx); end
  endtask

  task automatic test_frame_a3();
    logic [9:0] pat;
    pat = {1'b1, 8'hA3, 1'b0};
    data = 8'hA3;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      tick();
      total++; if (tx !== pat[k/C]) begin bad++; $display("FAIL a3_tx cyc=%0d got=%b want=%b", k, tx, pat[k/C]); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL a3_busy cyc=%0d got=%b want=1", k, busy); end
    end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL a3_busy_after got=%b want=0", busy); end
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL a3_tx_after got=%b want=1", tx); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    bytes = '{8'h55, 8'h0F, 8'hFF};
    for (int i = 0; i < 3; i++) begin
      data = bytes[i];
      data_valid = 1'b1;
      total++; if (data_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready i=%0d got=%b want=1", i, data_ready); end
      tick();
    end
    data_valid = 1'b0;
    for (int k = 0; k < 3 * FRAME + 4; k++) begin
      tick();
      total++; if (tx !== exp_tx()) begin bad++; $display("FAIL b2b_tx cyc=%0d got=%b want=%b", k, tx, exp_tx()); end
      total++; if (busy !== exp_busy()) begin bad++; $display("FAIL b2b_busy cyc=%0d got=%b want=%b", k, busy, exp_busy()); end
    end
  endtask

  task automatic test_overflow();
    data = 8'h11;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      data = 8'h20 + 8'(i * 37);
      data_valid = 1'b1;
      total++; if (data_ready !== (i < D)) begin bad++; $display("FAIL ovf_ready i=%0d got=%b want=%b", i, data_ready, (i < D)); end
      tick();
    end
    data_valid = 1'b0;
    total++; if (data_ready !== 1'b0) begin bad++; $display("FAIL ovf_ready_full got=%b want=0", data_ready); end
    for (int k = 0; k < 5 * FRAME + 4; k++) begin
      tick();
      total++; if (tx !== exp_tx()) begin bad++; $display("FAIL ovf_tx cyc=%0d got=%b want=%b", k, tx, exp_tx()); end
      total++; if (data_ready !== m_ready) begin bad++; $display("FAIL ovf_ready_run cyc=%0d got=%b want=%b", k, data_ready, m_ready); end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ovf_drained busy got=%b want=0", busy); end
  endtask

  task automatic test_reset_mid_frame();
    bit reached;
    reached = 1'b0;
    data = 8'h81;
    data_valid = 1'b1;
    tick();
    data = 8'h7E;
    tick();
    data_valid = 1'b0;
    for (int k = 0; k < 100 && !reached; k++) begin
      if (m_pos == 4 * C + 1) reached = 1'b1;
      else tick();
    end
    total++; if (!reached) begin bad++; $display("FAIL rstmid_reach_bit3 got=timeout want=reached"); end
    total++; if (tx !== exp_tx()) begin bad++; $display("FAIL rstmid_bit3_tx got=%b want=%b", tx, exp_tx()); end
    rst = 1'b1;
    data_valid = 1'b1;
    data = 8'hC3;
    tick();
    rst = 1'b0;
    data_valid = 1'b0;
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL rstmid_tx got=%b want=1", tx); end
    total++; if (data_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b want=1", data_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    for (int k = 0; k < 2 * FRAME; k++) begin
      tick();
      total++; if (tx !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_quiet cyc=%0d got=%b%b want=10", k, tx, busy); end
    end
  endtask

  task automatic test_push_pop_same_edge();
    bit reached;
    reached = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data = 8'h3C + 8'(i * 29);
      data_valid = 1'b1;
      tick();
    end
    data_valid = 1'b0;
    total++; if (dut.u_fifo.count !== 3'(mq.size())) begin bad++; $display("FAIL pp_occ_pre got=%0d want=%0d", dut.u_fifo.count, mq.size()); end
    for (int k = 0; k < 2 * FRAME && !reached; k++) begin
      if (m_pos == FRAME - 1) reached = 1'b1;
      else tick();
    end
    total++; if (!reached) begin bad++; $display("FAIL pp_reach_stop_end got=timeout want=reached"); end
    data = 8'hD2;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    total++; if (dut.u_fifo.count !== 3'd3) begin bad++; $display("FAIL pp_occ got=%0d want=3", dut.u_fifo.count); end
    total++; if (data_ready !== 1'b1) begin bad++; $display("FAIL pp_ready got=%b want=1", data_ready); end
    for (int k = 0; k < 4 * FRAME + 4; k++) begin
      tick();
      total++; if (tx !== exp_tx()) begin bad++; $display("FAIL pp_tx cyc=%0d got=%b want=%b", k, tx, exp_tx()); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      data_valid = ($urandom_range(0, 5) == 0);
      data = 8'($urandom);
      rst = ($urandom_range(0, 399) == 0);
      tick();
      total++; if (tx !== exp_tx()) begin bad++; $display("FAIL rnd_tx cyc=%0d got=%b want=%b", k, tx, exp_tx()); end
      total++; if (data_ready !== m_ready) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", k, data_ready, m_ready); end
      total++; if (busy !== exp_busy()) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%b want=%b", k, busy, exp_busy()); end
    end
    rst = 1'b0;
    data_valid = 1'b0;
    for (int k = 0; k < (D + 1) * FRAME + 4; k++) begin
      tick();
      total++; if (tx !== exp_tx()) begin bad++; $display("FAIL rnd_drain_tx cyc=%0d got=%b want=%b", k, tx, exp_tx()); end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rnd_drained busy got=%b want=0", busy); end
  endtask

  initial begin
    test_reset();
    test_frame_a3();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    test_push_pop_same_edge();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
